// File: rtl/clk_div_prog.sv
// clk_div_prog: a programmable clock divider with NUM_CH independent channels.
// Each channel divides i_clk by a ratio N that can be changed at run time.
// For each channel it gives a divided clock with roughly 50% duty, and a
// one-cycle tick on that clock's rising edge.
//
// Ports
//   i_clk      system clock; all logic runs on its posedge
//   i_reset    synchronous, active-high reset
//   i_en       per-channel run enable
//   i_sync     pulse that restarts all enabled channels in phase
//   i_load     pulse that writes i_div_val to the shadow ratio of i_ch_sel
//   i_ch_sel   target channel for i_load
//   i_div_val  new ratio N (must be >= 2)
//   o_clk_out  divided outputs (registered)
//   o_tick     one-cycle pulse on each o_clk_out rising edge (registered)
//   o_err      one-cycle pulse when the previous cycle's load was rejected

module clk_div_ch #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_ld,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_clk,
  output logic             o_tick
);
  logic [CNT_W-1:0] r_shadow, r_active, r_cnt;
  logic             r_clk, r_tick;
  logic             w_wrap, w_swap;
  logic [CNT_W-1:0] w_act_nxt, w_half, w_cnt_nxt;

  assign w_wrap = (r_cnt == r_active - CNT_W'(1));
  // The active ratio takes the shadow value at any period boundary: a wrap,
  // a sync, or while the channel is parked. This uses the pre-load shadow,
  // so a load in the same cycle only takes effect at the following wrap.
  assign w_swap    = w_wrap || i_sync || !i_en;
  assign w_act_nxt = w_swap ? r_shadow : r_active;
  assign w_half    = w_act_nxt - (w_act_nxt >> 1);  // ceil(N/2)

  // A disabled channel parks at N-1 of the ratio it will run next. That way
  // the first enabled edge is a wrap and gives a tick straight away.
  always_comb begin
    w_cnt_nxt = r_cnt + CNT_W'(1);
    if (!i_en)                w_cnt_nxt = w_act_nxt - CNT_W'(1);
    else if (i_sync || w_wrap) w_cnt_nxt = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow <= CNT_W'(DEF_DIV);
      r_active <= CNT_W'(DEF_DIV);
      r_cnt    <= CNT_W'(DEF_DIV - 1);
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      if (i_ld) r_shadow <= i_div;
      r_active <= w_act_nxt;
      r_cnt    <= w_cnt_nxt;
      r_clk    <= i_en && (w_cnt_nxt < w_half);
      r_tick   <= i_en && (w_cnt_nxt == '0);
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
endmodule

module clk_div_prog #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 2,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_sync,
  input  logic              i_load,
  input  logic [CH_W-1:0]   i_ch_sel,
  input  logic [CNT_W-1:0]  i_div_val,
  output logic [NUM_CH-1:0] o_clk_out,
  output logic [NUM_CH-1:0] o_tick,
  output logic              o_err
);
  // Widened by one bit so the range check still works when NUM_CH is a power of 2.
  localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CH);

  logic              w_ld_ok;
  logic [NUM_CH-1:0] w_ld;
  logic              r_err;

  assign w_ld_ok = (i_div_val >= CNT_W'(2)) && ({1'b0, i_ch_sel} < NCH);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_ld[g] = i_load && w_ld_ok && (i_ch_sel == CH_W'(g));
      clk_div_ch #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_en   (i_en[g]),
        .i_sync (i_sync),
        .i_ld   (w_ld[g]),
        .i_div  (i_div_val),
        .o_clk  (o_clk_out[g]),
        .o_tick (o_tick[g])
      );
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) r_err <= 1'b0;
    else         r_err <= i_load && !w_ld_ok;
  end

  assign o_err = r_err;
endmodule
